// File: rtl/piece_dispenser_pkg.sv
// Shared piece/bag types for the 7-bag piece dispenser.
// Holds the bag unpack helper and the bag sanity check.
package piece_dispenser_pkg;

  typedef logic [2:0] piece_t;

  localparam piece_t      PIECE_NONE = 3'd7;
  localparam int unsigned BAG_SLOTS  = 7;
  localparam int unsigned BAG_W      = 21;

  typedef piece_t [BAG_SLOTS-1:0] bag_t;

  // Slot k of the packed bag sits at bits [3k+2:3k]; slot 0 is dealt first.
  function automatic bag_t unpack_bag(input logic [BAG_W-1:0] b);
    bag_t r;
    for (int k = 0; k < BAG_SLOTS; k++) begin
      r[k] = b[3*k +: 3];
    end
    return r;
  endfunction

  function automatic logic bag_has_none(input bag_t b);
    logic r;
    r = 1'b0;
    for (int k = 0; k < BAG_SLOTS; k++) begin
      if (b[k] == PIECE_NONE) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piece_dispenser_if.sv
// Bag-capture and piece-dealing signals between randomiser/game logic (master)
// and the dispenser (slave).
interface piece_dispenser_if
  import piece_dispenser_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic [BAG_W-1:0] bag;
  logic             bag_done;
  logic             newbag;
  logic             request;
  logic             piece_valid;
  piece_t           current_piece;
  logic             next_valid;
  piece_t           next_piece;
  logic [CNT_W-1:0] dealt_count;
  logic             bag_error;

  modport master (
    output bag, bag_done, request,
    input  newbag, piece_valid, current_piece, next_valid, next_piece, dealt_count, bag_error
  );

  modport slave (
    input  bag, bag_done, request,
    output newbag, piece_valid, current_piece, next_valid, next_piece, dealt_count, bag_error
  );

endinterface

// File: rtl/piece_dispenser.sv
// Double-buffered bag dispenser: captures finished bags into a staged buffer and
// deals pieces from an active buffer without a bubble at bag boundaries.
module piece_dispenser
  import piece_dispenser_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  piece_dispenser_if.slave  bus
);

  typedef enum logic {StIdle, StFlush} cap_state_e;

  cap_state_e       r_state;
  bag_t             r_active;
  bag_t             r_staged;
  logic [2:0]       r_idx;
  logic             r_loaded;
  logic             r_staged_valid;
  logic             r_newbag;
  logic             r_bag_error;
  logic [CNT_W-1:0] r_count;

  logic       w_active_valid;
  logic       w_pop;
  logic       w_handoff;
  logic       w_capture;
  bag_t       w_bag;
  logic [2:0] w_idx_next;

  assign w_bag          = unpack_bag(bus.bag);
  assign w_idx_next     = r_idx + 3'd1;
  assign w_active_valid = r_loaded && (r_idx != 3'd7);
  assign w_pop          = bus.request && w_active_valid;
  assign w_handoff      = r_staged_valid && (!w_active_valid || (w_pop && r_idx == 3'd6));
  // A staged slot freed by this cycle's handoff may be refilled on the same edge.
  assign w_capture      = (r_state == StIdle) && bus.bag_done && (!r_staged_valid || w_handoff);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StIdle;
      r_active       <= '1;
      r_staged       <= '1;
      r_idx          <= 3'd0;
      r_loaded       <= 1'b0;
      r_staged_valid <= 1'b0;
      r_newbag       <= 1'b0;
      r_bag_error    <= 1'b0;
      r_count        <= '0;
    end else begin
      if (w_pop) begin
        r_idx   <= w_idx_next;
        r_count <= r_count + 1'b1;
      end
      if (w_handoff) begin
        r_active       <= r_staged;
        r_idx          <= 3'd0;
        r_loaded       <= 1'b1;
        r_staged_valid <= 1'b0;
      end
      if (w_capture) begin
        r_staged       <= w_bag;
        r_staged_valid <= 1'b1;
        if (bag_has_none(w_bag)) r_bag_error <= 1'b1;
      end
      // Stay in flush until bag_done drops so one bag is never captured twice.
      unique case (r_state)
        StIdle: begin
          if (w_capture) begin
            r_state  <= StFlush;
            r_newbag <= 1'b1;
          end
        end
        StFlush: begin
          if (!bus.bag_done) begin
            r_state  <= StIdle;
            r_newbag <= 1'b0;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_newbag <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.piece_valid   = w_active_valid;
    bus.current_piece = PIECE_NONE;
    bus.next_valid    = 1'b0;
    bus.next_piece    = PIECE_NONE;
    if (w_active_valid) begin
      bus.current_piece = r_active[r_idx];
      if (r_idx < 3'd6) begin
        bus.next_valid = 1'b1;
        bus.next_piece = r_active[w_idx_next];
      end else if (r_staged_valid) begin
        bus.next_valid = 1'b1;
        bus.next_piece = r_staged[0];
      end
    end
  end

  assign bus.newbag      = r_newbag;
  assign bus.dealt_count = r_count;
  assign bus.bag_error   = r_bag_error;

endmodule

// File: tb/tb_piece_dispenser.sv
// Self-checking bench for piece_dispenser: directed scenarios plus a random phase,
// all compared against a queue-based model of the dealing rules.
module tb_piece_dispenser;
  import piece_dispenser_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic reset;

  piece_dispenser_if #(.CNT_W(CNT_W)) bus ();

  piece_dispenser #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: remaining pieces of the active bag, the staged bag, and whether a new
  // capture is allowed (bag_done seen low since the last capture).
  logic [2:0]  m_act[$];
  logic [2:0]  m_stg[7];
  bit          m_stg_v;
  bit          m_armed;
  bit          m_err;
  int unsigned m_cnt;

  function automatic logic [20:0] pack7(input int s0, s1, s2, s3, s4, s5, s6);
    logic [20:0] b;
    b = {s6[2:0], s5[2:0], s4[2:0], s3[2:0], s2[2:0], s1[2:0], s0[2:0]};
    return b;
  endfunction

  function automatic logic [20:0] rand_bag();
    logic [20:0] b;
    for (int k = 0; k < 7; k++) b[3*k +: 3] = 3'($urandom_range(0, 6));
    return b;
  endfunction

  function void model_reset();
    m_act.delete();
    m_stg_v = 1'b0;
    m_armed = 1'b1;
    m_err   = 1'b0;
    m_cnt   = 0;
  endfunction

  function void model_edge();
    bit pop, handoff, capture;
    pop     = bus.request && (m_act.size() > 0);
    handoff = m_stg_v && (m_act.size() == 0 || (pop && m_act.size() == 1));
    capture = m_armed && bus.bag_done && (!m_stg_v || handoff);
    if (pop) begin
      void'(m_act.pop_front());
      m_cnt++;
    end
    if (handoff) begin
      m_act.delete();
      for (int k = 0; k < 7; k++) m_act.push_back(m_stg[k]);
      m_stg_v = 1'b0;
    end
    if (capture) begin
      for (int k = 0; k < 7; k++) begin
        m_stg[k] = bus.bag[3*k +: 3];
        if (m_stg[k] == 3'd7) m_err = 1'b1;
      end
      m_stg_v = 1'b1;
      m_armed = 1'b0;
    end else if (!m_armed && !bus.bag_done) begin
      m_armed = 1'b1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] ec, en;
    bit         ev, env;
    ev = m_act.size() > 0;
    ec = ev ? m_act[0] : 3'd7;
    if (m_act.size() >= 2) begin
      en = m_act[1]; env = 1'b1;
    end else if (m_act.size() == 1 && m_stg_v) begin
      en = m_stg[0]; env = 1'b1;
    end else begin
      en = 3'd7; env = 1'b0;
    end
    check({tag, ".piece_valid"}, 32'(bus.piece_valid), 32'(ev));
    check({tag, ".current"}, 32'(bus.current_piece), 32'(ec));
    check({tag, ".next_valid"}, 32'(bus.next_valid), 32'(env));
    check({tag, ".next"}, 32'(bus.next_piece), 32'(en));
    check({tag, ".newbag"}, 32'(bus.newbag), 32'(!m_armed));
    check({tag, ".count"}, 32'(bus.dealt_count), m_cnt & 32'hFFFF);
    check({tag, ".bag_error"}, 32'(bus.bag_error), 32'(m_err));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    reset        = 1'b1;
    bus.bag      = '0;
    bus.bag_done = 1'b0;
    bus.request  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // 1: capture, newbag, two-edge latency to first piece
    bus.bag      = pack7(6, 5, 4, 3, 2, 1, 0);
    bus.bag_done = 1'b1;
    step("t1_cap");
    check("t1_newbag", 32'(bus.newbag), 32'd1);
    check("t1_pv_early", 32'(bus.piece_valid), 32'd0);
    step("t1_load");
    check("t1_cur", 32'(bus.current_piece), 32'd6);
    check("t1_next", 32'(bus.next_piece), 32'd5);
    bus.bag_done = 1'b0;
    step("t1_drop");
    check("t1_newbag_low", 32'(bus.newbag), 32'd0);

    // 2: deal the whole bag with nothing staged
    bus.request = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("t2_cur", 32'(bus.current_piece), 32'(6 - i));
      if (i == 6) check("t2_nv_idx6", 32'(bus.next_valid), 32'd0);
      step("t2_pop");
    end
    check("t2_empty_cur", 32'(bus.current_piece), 32'd7);
    step("t2_ignored");
    check("t2_count", 32'(bus.dealt_count), 32'd7);
    bus.request = 1'b0;

    // 3: second bag staged before the last slot goes, no bubble
    bus.bag      = pack7(1, 2, 3, 4, 5, 6, 0);
    bus.bag_done = 1'b1;
    step("t3_capA");
    bus.bag_done = 1'b0;
    step("t3_loadA");
    bus.bag      = pack7(4, 1, 5, 2, 6, 0, 3);
    bus.bag_done = 1'b1;
    step("t3_capB");
    bus.bag_done = 1'b0;
    bus.request  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("t3_pop");
      check("t3_pv", 32'(bus.piece_valid), 32'd1);
    end
    check("t3_preview", 32'(bus.next_piece), 32'd4);
    step("t3_boundary");
    check("t3_cur_B0", 32'(bus.current_piece), 32'd4);
    check("t3_pv_boundary", 32'(bus.piece_valid), 32'd1);
    bus.request = 1'b0;

    // 4: bag_done held across a handoff must not capture a second time
    bus.bag      = pack7(0, 1, 2, 3, 4, 5, 6);
    bus.bag_done = 1'b1;
    step("t4_cap");
    bus.request = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step("t4_hold");
      check("t4_newbag", 32'(bus.newbag), 32'd1);
    end
    bus.request  = 1'b0;
    bus.bag_done = 1'b0;
    step("t4_release");

    // 5: bad bag sets the sticky error, then random traffic with clean bags
    bus.bag      = pack7(0, 1, 2, 7, 4, 5, 6);
    bus.bag_done = 1'b1;
    step("t5_cap");
    check("t5_err", 32'(bus.bag_error), 32'd1);
    for (int i = 0; i < 300; i++) begin
      bus.bag      = rand_bag();
      bus.bag_done = ($urandom_range(0, 3) == 0);
      bus.request  = ($urandom_range(0, 2) != 0);
      step("rand");
    end
    check("t5_err_sticky", 32'(bus.bag_error), 32'd1);

    // 6: asynchronous reset mid-bag with flush active
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    bus.request  = 1'b0;
    bus.bag      = pack7(2, 3, 4, 5, 6, 0, 1);
    bus.bag_done = 1'b1;
    step("t6_cap");
    step("t6_load");
    bus.request = 1'b1;
    repeat (3) step("t6_pop");
    bus.request = 1'b0;
    check("t6_cur_idx3", 32'(bus.current_piece), 32'd5);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("t6_async");
    check("t6_newbag", 32'(bus.newbag), 32'd0);
    check("t6_count", 32'(bus.dealt_count), 32'd0);
    @(negedge clk);
    reset        = 1'b0;
    bus.bag_done = 1'b0;
    step("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
